// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit digit-serial adder with carry-in, carry-out and
// two's-complement overflow. One DIGIT-bit slice is added per clock, least
// significant slice first, and the carry ripples through a register.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, a 'sub' input exists. sub=1 loads ~b and forces the
//   initial carry to 1, so the block computes a - b (cout=1 means no borrow).
//
// Handshake: 'start' is a request that is only accepted while the block is
// idle or is showing a result (busy=0). The request is consumed on the
// accepting clock edge, and the operands are captured on that same edge.
// While busy=1 the block ignores start, and it does not queue the request.
// 'done' is a one-cycle pulse. sum/cout/ovf are valid from that pulse and
// hold until the next completion or a reset.
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Operand shift registers, carry, digit counter and the working result
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_w;
    logic             r_amsb;
    logic             r_bmsb;

    // Registered results
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    // Control strobes from the FSM
    logic w_load;
    logic w_step;
    logic w_last;

    // Effective B operand and initial carry, after optional subtract select
    logic [WIDTH-1:0] w_b_in;
    logic             w_c_in;

    // Per-digit adder and the working register's next value
    logic [DIGIT:0]   w_dsum;
    logic [WIDTH-1:0] w_w_next;
    logic             w_ovf_next;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1; cin has no effect when sub is set
    assign w_b_in = sub ? ~b : b;
    assign w_c_in = sub ? 1'b1 : cin;
`else
    assign w_b_in = b;
    assign w_c_in = cin;
`endif

    assign w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, r_c};

    // New digit enters the working register from the top; with a single digit
    // the digit is the whole result
    generate
        if (NDIG == 1) begin : g_single
            assign w_w_next = w_dsum[DIGIT-1:0];
        end else begin : g_multi
            assign w_w_next = {w_dsum[DIGIT-1:0], r_w[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Overflow: operands agree in sign but the result does not
    assign w_ovf_next = (r_amsb == r_bmsb) && (w_w_next[WIDTH-1] != r_amsb);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and datapath strobes
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture and per-digit shifting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_w    <= '0;
            r_amsb <= 1'b0;
            r_bmsb <= 1'b0;
        end else if (w_load) begin
            r_a    <= a;
            r_b    <= w_b_in;
            r_c    <= w_c_in;
            r_cnt  <= '0;
            r_amsb <= a[WIDTH-1];
            r_bmsb <= w_b_in[WIDTH-1];
        end else if (w_step) begin
            r_a   <= r_a >> DIGIT;
            r_b   <= r_b >> DIGIT;
            r_c   <= w_dsum[DIGIT];
            r_w   <= w_w_next;
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Results update only when the final digit completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_last) begin
            r_sum  <= w_w_next;
            r_cout <= w_dsum[DIGIT];
            r_ovf  <= w_ovf_next;
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder: a 16/4 instance for the main scenarios
// and an 8/8 instance for the single-digit case.
module tb_serial_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [1:0]  dbg_state;

    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        cin8;
    logic        sub8;
    logic        busy8;
    logic        done8;
    logic [7:0]  sum8;
    logic        cout8;
    logic        ovf8;
    logic [1:0]  dbg_state8;

    int n_checks;
    int n_fail;
    logic [15:0] exp_q[$];

    serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    serial_adder #(.WIDTH(8), .DIGIT(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub8),
`endif
        .busy      (busy8),
        .done      (done8),
        .sum       (sum8),
        .cout      (cout8),
        .ovf       (ovf8),
        .dbg_state (dbg_state8)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation on the 16/4 instance and check latency, busy length
    // and results. Operands are scrambled right after acceptance.
    task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                          input logic icin, input logic isub, input logic [15:0] esum,
                          input logic ecout, input logic eovf);
        int edges;
        int busy_cnt;
        logic [15:0] held;
        exp_q.push_back(esum);
        @(negedge clk);
        a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom_range(0, 65535));
        b = 16'($urandom_range(0, 65535));
        cin = ~icin;
        sub = ~isub;
        edges = 0;
        busy_cnt = 0;
        while (!done && edges < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            edges++;
        end
        check({tag, "_latency"}, edges, 4);
        check({tag, "_busy_cycles"}, busy_cnt, 4);
        check({tag, "_busy_at_done"}, busy, 0);
        held = exp_q.pop_front();
        check({tag, "_sum"}, sum, held);
        check({tag, "_cout"}, cout, ecout);
        check({tag, "_ovf"}, ovf, eovf);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_sum_held"}, sum, held);
    endtask

    initial begin
        int cyc;
        int last_done;
        int n_done;
        int edges;

        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        start = 0; a = 0; b = 0; cin = 0; sub = 0;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);

        // Directed additions
        run_op("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_7fff_cin", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("add_8000_8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("add_00ff_0f01", 16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub_5_7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("sub0_add", 16'h0003, 16'h0004, 1'b1, 1'b0, 16'h0008, 1'b0, 1'b0);
`endif

        // Back-to-back: start held high, one result per 5 cycles
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; cin = 0; sub = 0; start = 1'b1;
        last_done = -1;
        n_done = 0;
        for (cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                check("b2b_sum", sum, 16'h0002);
                if (last_done >= 0) check("b2b_interval", cyc - last_done, 5);
                last_done = cyc;
            end
        end
        check("b2b_count", n_done, 3);
        start = 1'b0;
        edges = 0;
        while (!done && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check("b2b_drain", done, 1);
        @(negedge clk);

        // Reset two cycles into an operation
        a = 16'h0F0F; b = 16'h0101; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        check("abort_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        check("abort_sum_stays", sum, 0);
        run_op("after_abort", 16'hA5A5, 16'h1111, 1'b0, 1'b0, 16'hB6B6, 1'b0, 1'b0);

        // Single-digit instance: done one cycle after start
        @(negedge clk);
        a8 = 8'hC8; b8 = 8'h64; cin8 = 0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'h00; b8 = 8'h00;
        check("w8_busy", busy8, 1);
        edges = 0;
        while (!done8 && edges < 10) begin
            @(negedge clk);
            edges++;
        end
        check("w8_latency", edges, 1);
        check("w8_sum", sum8, 8'h2C);
        check("w8_cout", cout8, 1);
        check("w8_ovf", ovf8, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
